// File: rtl/interrupt_sequencer_if.sv
// Bundle of controller, PC-path and status signals for interrupt_sequencer.
// The master modport drives the sequencer inputs; the slave modport is the sequencer itself.
interface interrupt_sequencer_if #(
   parameter int AW    = 10,
   parameter int DEPTH = 4
);
   localparam int DW = $clog2(DEPTH) + 1;

   logic          s_interruption;
   logic [AW-1:0] dir_in;
   logic [AW-1:0] pc_next;
   logic          pc_en;
   logic          instr_reti;
   logic          flag_z_in;
   logic          pc_load;
   logic [AW-1:0] pc_target;
   logic          stall;
   logic          s_finished;
   logic          in_isr;
   logic [DW-1:0] depth;
   logic          stack_err;
   logic          flag_z_out;
   logic          flag_restore;

   modport master (
      output s_interruption, dir_in, pc_next, pc_en, instr_reti, flag_z_in,
      input  pc_load, pc_target, stall, s_finished, in_isr, depth, stack_err,
             flag_z_out, flag_restore
   );

   modport slave (
      input  s_interruption, dir_in, pc_next, pc_en, instr_reti, flag_z_in,
      output pc_load, pc_target, stall, s_finished, in_isr, depth, stack_err,
             flag_z_out, flag_restore
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt entry/return sequencer with a LIFO return-address stack.
// Optional macro ISEQ_SAVE_FLAGS_EN: also stacks and restores the ALU zero flag.
module interrupt_sequencer #(
   parameter int AW    = 10,
   parameter int DEPTH = 4
) (
   input logic                  clk,
   input logic                  reset,
   interrupt_sequencer_if.slave bus
);
   localparam int DW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);
`ifdef ISEQ_SAVE_FLAGS_EN
   localparam int EW = AW + 1;
`else
   localparam int EW = AW;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAVE,
      S_VECTOR,
      S_ISR,
      S_RETURN
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_pending;
   logic [AW-1:0] r_vec;
   logic [DW-1:0] r_depth;
   logic          r_stack_err;
   logic [EW-1:0] r_stack [DEPTH];

   logic          w_full;
   logic          w_empty;
   logic          w_take;
   logic          w_push;
   logic          w_pop;
   logic          w_err_set;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_rd_idx;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_top;

   logic          w_pc_load;
   logic [AW-1:0] w_pc_target;
   logic          w_stall;
   logic          w_finished;
   logic          w_in_return;

   assign w_full   = (r_depth == DW'(DEPTH));
   assign w_empty  = (r_depth == '0);
   // Only meaningful when not full; when full the index wraps to 0, which is
   // exactly what makes w_rd_idx land on the top slot (DEPTH-1).
   assign w_wr_idx = r_depth[IW-1:0];
   assign w_rd_idx = w_wr_idx - IW'(1);
   assign w_top    = r_stack[w_rd_idx];

`ifdef ISEQ_SAVE_FLAGS_EN
   assign w_entry = {bus.flag_z_in, bus.pc_next};
`else
   assign w_entry = bus.pc_next;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state always uses non-blocking assignment so every
         // flop samples pre-edge values regardless of block ordering.
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves a signal unassigned and a latch is inferred.
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_err_set   = 1'b0;
      w_pc_load   = 1'b0;
      w_pc_target = '0;
      w_stall     = 1'b0;
      w_finished  = 1'b0;
      w_in_return = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.pc_en) begin
               if (bus.instr_reti) w_err_set = 1'b1;
               if (r_pending) begin
                  w_state_nxt = S_SAVE;
                  w_take      = 1'b1;
               end
            end
         end
         S_ISR: begin
            // A reti at the same boundary wins; the pending request waits.
            if (bus.pc_en) begin
               if (bus.instr_reti) begin
                  w_state_nxt = S_RETURN;
               end else if (r_pending) begin
                  w_state_nxt = S_SAVE;
                  w_take      = 1'b1;
               end
            end
         end
         S_SAVE: begin
            w_stall = 1'b1;
            if (w_full) begin
               // Dropped request; a full stack can only mean we came from ISR.
               w_err_set   = 1'b1;
               w_finished  = 1'b1;
               w_state_nxt = S_ISR;
            end else begin
               w_push      = 1'b1;
               w_state_nxt = S_VECTOR;
            end
         end
         S_VECTOR: begin
            w_stall     = 1'b1;
            w_pc_load   = 1'b1;
            w_pc_target = r_vec;
            w_state_nxt = S_ISR;
         end
         S_RETURN: begin
            w_stall     = 1'b1;
            w_pc_load   = 1'b1;
            w_pc_target = w_top[AW-1:0];
            w_finished  = 1'b1;
            w_in_return = 1'b1;
            if (w_empty) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_pop       = 1'b1;
               w_state_nxt = (r_depth > DW'(1)) ? S_ISR : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Request latch: a new request always wins over the clear on service.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
         r_vec     <= '0;
      end else if (bus.s_interruption) begin
         r_pending <= 1'b1;
         r_vec     <= bus.dir_in;
      end else if (w_take) begin
         r_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_depth     <= '0;
         r_stack_err <= 1'b0;
      end else begin
         if (w_push)         r_depth <= r_depth + DW'(1);
         else if (w_pop)     r_depth <= r_depth - DW'(1);
         if (w_err_set)      r_stack_err <= 1'b1;
      end
   end

   // NOTE: the stack storage has no reset; occupancy is tracked by r_depth, so
   // stale entries are never read and clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[w_wr_idx] <= w_entry;
   end

   assign bus.pc_load    = w_pc_load;
   assign bus.pc_target  = w_pc_target;
   assign bus.stall      = w_stall;
   assign bus.s_finished = w_finished;
   assign bus.in_isr     = !w_empty;
   assign bus.depth      = r_depth;
   assign bus.stack_err  = r_stack_err;

`ifdef ISEQ_SAVE_FLAGS_EN
   assign bus.flag_z_out   = w_in_return & w_top[EW-1];
   assign bus.flag_restore = w_in_return;
`else
   logic w_unused_flags;
   assign w_unused_flags   = bus.flag_z_in ^ w_in_return;
   assign bus.flag_z_out   = 1'b0;
   assign bus.flag_restore = 1'b0;
`endif
endmodule
